// File: rtl/eq_pkg.sv
// eq_pkg: shared types and default sizing for the equalizer tap sequencer.
package eq_pkg;

    localparam int EQ_NUM_TAPS = 4;
    localparam int EQ_DATA_W   = 16;
    localparam int EQ_COEF_W   = 16;
    localparam int EQ_FRAC     = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } eq_state_e;

    // Accumulator sized so NUM_TAPS full-scale products can never overflow.
    function automatic int eq_acc_width(input int data_w, input int coef_w, input int num_taps);
        return data_w + coef_w + $clog2(num_taps);
    endfunction

endpackage

// File: rtl/eq_tap_sequencer_if.sv
// eq_tap_sequencer_if: sample stream into the sequencer and filtered result out.
// master = sample source / result consumer, slave = sequencer.
interface eq_tap_sequencer_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;
    logic signed [DATA_W-1:0] sample_out;
    logic                     out_valid;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready,
        input  sample_out,
        input  out_valid
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready,
        output sample_out,
        output out_valid
    );
endinterface

// File: rtl/eq_history_buf.sv
// eq_history_buf: NUM_TAPS-deep circular sample history.
// Reads are addressed as (base - offset) mod NUM_TAPS so tap k sees x[n-k].
// Every entry returns to zero while reset is asserted.
module eq_history_buf #(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we_i,
    input  logic [$clog2(NUM_TAPS)-1:0]   wr_addr_i,
    input  logic signed [DATA_W-1:0]      wr_data_i,
    input  logic [$clog2(NUM_TAPS)-1:0]   rd_base_i,
    input  logic [$clog2(NUM_TAPS)-1:0]   rd_off_i,
    output logic signed [DATA_W-1:0]      rd_data_o
);
    localparam int PW = $clog2(NUM_TAPS);

    logic signed [DATA_W-1:0] mem_q [NUM_TAPS];
    logic [PW-1:0]            rd_idx;

    // Sample storage: cleared on reset, one write per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Wrapped read index; adding NUM_TAPS in PW bits stays correct even when
    // NUM_TAPS is a power of two (the addend truncates to zero).
    always_comb begin
        if (rd_base_i >= rd_off_i) begin
            rd_idx = rd_base_i - rd_off_i;
        end else begin
            rd_idx = rd_base_i - rd_off_i + PW'(NUM_TAPS);
        end
    end

    assign rd_data_o = mem_q[rd_idx];

endmodule

// File: rtl/eq_tap_sequencer.sv
// eq_tap_sequencer: one signed MAC time-shared across all equalizer taps.
// Each accepted sample is written to the history, then NUM_TAPS products
// coef[k] * x[n-k] are accumulated, rounded, limited and emitted once.
// eq_val is sampled only on accept so the coefficient bank is stable for a
// whole computation.
// Build option EQ_SEQ_SAT_EN: clamp the rounded result to the DATA_W range;
// without it the result wraps to its low DATA_W bits.
//
// state   | meaning
// ST_IDLE | ready for a sample, nothing in flight
// ST_FILL | bank is fetching tap 0, no product available yet
// ST_MAC  | one tap product accumulated per cycle, NUM_TAPS cycles
// ST_DONE | round/limit the accumulator, result valid the next cycle
module eq_tap_sequencer
    import eq_pkg::*;
#(
    parameter int NUM_TAPS = EQ_NUM_TAPS,
    parameter int DATA_W   = EQ_DATA_W,
    parameter int COEF_W   = EQ_COEF_W,
    parameter int FRAC     = EQ_FRAC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               eq_val,
    output logic [7:0]               eq_active,
    output logic [7:0]               tapnum,
    input  logic signed [COEF_W-1:0] coef,
    output logic                     busy,
    eq_tap_sequencer_if.slave        smp
);
    localparam int PW  = $clog2(NUM_TAPS);
    localparam int PRW = DATA_W + COEF_W;
    localparam int AW  = eq_acc_width(DATA_W, COEF_W, NUM_TAPS);

`ifdef EQ_SEQ_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [PW-1:0] LAST_K   = PW'(NUM_TAPS - 1);
    localparam logic [7:0]    LAST_TAP = 8'(NUM_TAPS - 1);

    eq_state_e                state_q, state_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            k_q, k_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [7:0]               tapnum_q, tapnum_d;
    logic [7:0]               eq_active_q, eq_active_d;
    logic signed [DATA_W-1:0] sample_out_q, sample_out_d;
    logic                     out_valid_q, out_valid_d;

    logic                     hist_we;
    logic signed [DATA_W-1:0] hist_rd;
    logic signed [PRW-1:0]    prod;
    logic signed [AW-1:0]     prod_ext;
    logic signed [AW:0]       acc_ext;
    logic signed [AW:0]       rnd_full;
    logic                     ovf;
    logic signed [DATA_W-1:0] result;

    eq_history_buf #(
        .NUM_TAPS (NUM_TAPS),
        .DATA_W   (DATA_W)
    ) u_hist (
        .clk       (clk),
        .rst_n     (reset),
        .we_i      (hist_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (smp.sample_in),
        .rd_base_i (wr_ptr_q),
        .rd_off_i  (k_q),
        .rd_data_o (hist_rd)
    );

    assign prod     = PRW'(coef) * PRW'(hist_rd);
    assign prod_ext = $signed({{(AW - PRW){prod[PRW-1]}}, prod});

    // One guard bit keeps the rounding add from wrapping at the extremes.
    assign acc_ext = {acc_q[AW-1], acc_q};

    generate
        if (FRAC == 0) begin : g_no_round
            assign rnd_full = acc_ext;
        end else begin : g_round
            localparam logic signed [AW:0] HALF = (AW + 1)'(1) << (FRAC - 1);
            assign rnd_full = (acc_ext + HALF) >>> FRAC;
        end
    endgenerate

    // Out of range when the bits above the DATA_W sign bit disagree with it.
    assign ovf = !(&rnd_full[AW:DATA_W-1]) && (|rnd_full[AW:DATA_W-1]);

    // Clamp or wrap the rounded value into DATA_W bits.
    always_comb begin
        result = rnd_full[DATA_W-1:0];
        if (SAT_EN && ovf) begin
            result = rnd_full[AW] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // State and datapath registers; reset discards any in-flight sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            tapnum_q     <= '0;
            eq_active_q  <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            tapnum_q     <= tapnum_d;
            eq_active_q  <= eq_active_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Next-state and datapath control for the accept/fill/MAC/done sequence.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        k_d          = k_q;
        acc_d        = acc_q;
        tapnum_d     = tapnum_q;
        eq_active_d  = eq_active_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        hist_we      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (smp.sample_valid) begin
                    hist_we     = 1'b1;
                    eq_active_d = eq_val;
                    acc_d       = '0;
                    tapnum_d    = '0;
                    k_d         = '0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                tapnum_d = 8'd1;
                state_d  = ST_MAC;
            end
            ST_MAC: begin
                acc_d = acc_q + prod_ext;
                if (tapnum_q != LAST_TAP) begin
                    tapnum_d = tapnum_q + 8'd1;
                end
                if (k_q == LAST_K) begin
                    wr_ptr_d = (wr_ptr_q == LAST_K) ? '0 : wr_ptr_q + 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                sample_out_d = result;
                out_valid_d  = 1'b1;
                tapnum_d     = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign eq_active        = eq_active_q;
    assign tapnum           = tapnum_q;
    assign busy             = (state_q != ST_IDLE);
    assign smp.sample_ready = (state_q == ST_IDLE);
    assign smp.sample_out   = sample_out_q;
    assign smp.out_valid    = out_valid_q;

endmodule

// File: tb/tb_eq_tap_sequencer.sv
// Bench for eq_tap_sequencer with NUM_TAPS=4, FRAC=0 and a registered stub
// coefficient bank (coef = tapnum + 4, or a fixed 0x7FFF).
module tb_eq_tap_sequencer;

    logic              clk;
    logic              reset;
    logic [7:0]        eq_val;
    logic [7:0]        eq_active;
    logic [7:0]        tapnum;
    logic signed [15:0] coef;
    logic              busy;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  coef_fixed = 1'b0;

    logic [15:0] exp_q[$];
    int          hist_m[4];
    int          ptr_m = 0;

    eq_tap_sequencer_if #(.DATA_W(16)) smp_if ();

    eq_tap_sequencer #(
        .NUM_TAPS (4),
        .DATA_W   (16),
        .COEF_W   (16),
        .FRAC     (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .eq_val    (eq_val),
        .eq_active (eq_active),
        .tapnum    (tapnum),
        .coef      (coef),
        .busy      (busy),
        .smp       (smp_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stub coefficient bank: registered, one cycle behind tapnum.
    always @(posedge clk) coef <= coef_fixed ? 16'sh7FFF : $signed(16'(tapnum + 8'd4));

    // Scoreboard consumer: every out_valid must match the oldest expected value.
    always @(negedge clk) begin
        if (reset && smp_if.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: sample_out=%h with nothing expected", smp_if.sample_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (smp_if.sample_out !== e) begin
                    errors++;
                    $display("FAIL sample_out: got %h expected %h", smp_if.sample_out, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) hist_m[i] = 0;
        ptr_m = 0;
    endtask

    // Reference filter: written independently of the RTL structure.
    task automatic model_accept(input logic [15:0] s);
        longint acc;
        logic [15:0] res;
        hist_m[ptr_m] = int'($signed(s));
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            longint c;
            c = coef_fixed ? 32767 : (4 + k);
            acc += c * longint'(hist_m[(ptr_m - k + 4) % 4]);
        end
        ptr_m = (ptr_m + 1) % 4;
`ifdef EQ_SEQ_SAT_EN
        if (acc > 32767) res = 16'h7FFF;
        else if (acc < -32768) res = 16'h8000;
        else res = acc[15:0];
`else
        res = acc[15:0];
`endif
        exp_q.push_back(res);
    endtask

    task automatic do_reset();
        smp_if.sample_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Offer a sample; returns once it is accepted (acc_cyc = cycle count).
    task automatic send_sample(input logic [15:0] s, input logic [7:0] ev, input bit hold, output int acc_cyc);
        int n;
        n = 0;
        smp_if.sample_in    = s;
        smp_if.sample_valid = 1'b1;
        eq_val              = ev;
        while (!smp_if.sample_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_timeout: sample %h not accepted within %0d cycles", s, n);
            smp_if.sample_valid = 1'b0;
            acc_cyc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            model_accept(s);
            if (!hold) smp_if.sample_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !smp_if.sample_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, ready=%b", exp_q.size(), smp_if.sample_ready);
        end
    endtask

    task automatic test_reset();
        smp_if.sample_in    = '0;
        smp_if.sample_valid = 1'b0;
        eq_val              = 8'h00;
        reset               = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks += 6;
        if (smp_if.sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", smp_if.sample_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (smp_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", smp_if.out_valid); end
        if (smp_if.sample_out !== 16'h0000) begin errors++; $display("FAIL reset_sample_out: got %h expected 0000", smp_if.sample_out); end
        if (tapnum !== 8'h00) begin errors++; $display("FAIL reset_tapnum: got %h expected 00", tapnum); end
        if (eq_active !== 8'h00) begin errors++; $display("FAIL reset_eq_active: got %h expected 00", eq_active); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Single sample: per-cycle tapnum, ready and out_valid timing.
    task automatic test_single();
        int t;
        int exp_tap[7];
        exp_tap = '{0, 1, 2, 3, 3, 3, 0};
        send_sample(16'd1, 8'h11, 1'b0, t);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks += 3;
            if (tapnum !== 8'(exp_tap[i])) begin errors++; $display("FAIL single_tapnum[%0d]: got %0d expected %0d", i, tapnum, exp_tap[i]); end
            if (smp_if.out_valid !== (i == 6)) begin errors++; $display("FAIL single_out_valid[%0d]: got %b expected %b", i, smp_if.out_valid, (i == 6)); end
            if (smp_if.sample_ready !== (i == 6)) begin errors++; $display("FAIL single_ready[%0d]: got %b expected %b", i, smp_if.sample_ready, (i == 6)); end
        end
        drain();
    endtask

    task automatic test_impulse();
        int t;
        logic [15:0] seq[5];
        seq = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        do_reset();
        foreach (seq[i]) send_sample(seq[i], 8'h22, 1'b0, t);
        drain();
    endtask

    task automatic test_saturate();
        int t;
        do_reset();
        coef_fixed = 1'b1;
        @(negedge clk);
        send_sample(16'h7FFF, 8'h33, 1'b0, t);
        drain();
        send_sample(16'h8000, 8'h33, 1'b0, t);
        drain();
        coef_fixed = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_eq_hold();
        int t;
        send_sample(16'd3, 8'hF4, 1'b0, t);
        @(negedge clk);
        checks++;
        if (eq_active !== 8'hF4) begin errors++; $display("FAIL eq_latch: got %h expected f4", eq_active); end
        @(negedge clk);
        eq_val = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (eq_active !== 8'hF4) begin errors++; $display("FAIL eq_hold[%0d]: got %h expected f4", i, eq_active); end
        end
        send_sample(16'd5, 8'h00, 1'b0, t);
        @(negedge clk);
        checks++;
        if (eq_active !== 8'h00) begin errors++; $display("FAIL eq_update: got %h expected 00", eq_active); end
        drain();
    endtask

    task automatic test_reset_mid_mac();
        int t;
        send_sample(16'd1, 8'h44, 1'b0, t);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (smp_if.sample_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", smp_if.sample_ready); end
        if (tapnum !== 8'h00) begin errors++; $display("FAIL midrst_tapnum: got %h expected 00", tapnum); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (smp_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output[%0d]: out_valid got %b expected 0", i, smp_if.out_valid); end
        end
        send_sample(16'd1, 8'h44, 1'b0, t);
        drain();
    endtask

    task automatic test_back_to_back();
        int t1, t2, t3;
        do_reset();
        send_sample(16'd1, 8'h55, 1'b1, t1);
        send_sample(16'd2, 8'h55, 1'b1, t2);
        send_sample(16'd3, 8'h55, 1'b0, t3);
        checks += 2;
        if (t2 - t1 != 7) begin errors++; $display("FAIL b2b_spacing_1: got %0d cycles expected 7", t2 - t1); end
        if (t3 - t2 != 7) begin errors++; $display("FAIL b2b_spacing_2: got %0d cycles expected 7", t3 - t2); end
        drain();
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_single();
        test_impulse();
        test_saturate();
        test_eq_hold();
        test_reset_mid_mac();
        test_back_to_back();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
